// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI-Lite arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; prio names the master that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // A lone requester always wins; on a tie the prio pointer decides.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_lite_arb2.sv
// Two-master AXI-Lite arbiter: independent write and read FSMs, each with a
// registered one-hot grant and round-robin priority. Payload and handshakes are
// routed combinationally to/from the granted master.
//
// state  | meaning
// W_IDLE | no write owner, arbitrating AW requests
// W_ADDR | forwarding AW and W of the granted master until both handshake
// W_RESP | routing B back to the granted master
// R_IDLE | no read owner, arbitrating AR requests
// R_ADDR | forwarding AR of the granted master
// R_DATA | routing R back to the granted master
module axi_lite_arb2
  import axi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [1:0]              wr_grant,
  output logic [1:0]              rd_grant
);

  wr_state_t r_wr_state, w_wr_state_nxt;
  rd_state_t r_rd_state, w_rd_state_nxt;
  logic [1:0] r_wr_grant, w_wr_grant_nxt, r_rd_grant, w_rd_grant_nxt;
  logic       r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;
  logic       r_wr_prio, w_wr_prio_nxt, r_rd_prio, w_rd_prio_nxt;
  logic [1:0] w_wr_pick, w_rd_pick;
  logic       w_wr_addr, w_wr_resp, w_rd_addr, w_rd_data;
  logic       w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;
  logic       w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  rr_arb2 u_wr_arb (.req({s1_axi_awvalid, s0_axi_awvalid}), .prio(r_wr_prio), .gnt(w_wr_pick));
  rr_arb2 u_rd_arb (.req({s1_axi_arvalid, s0_axi_arvalid}), .prio(r_rd_prio), .gnt(w_rd_pick));

  assign w_wr_addr = (r_wr_state == W_ADDR);
  assign w_wr_resp = (r_wr_state == W_RESP);
  assign w_rd_addr = (r_rd_state == R_ADDR);
  assign w_rd_data = (r_rd_state == R_DATA);

  assign w_g_awvalid = (r_wr_grant[0] & s0_axi_awvalid) | (r_wr_grant[1] & s1_axi_awvalid);
  assign w_g_wvalid  = (r_wr_grant[0] & s0_axi_wvalid)  | (r_wr_grant[1] & s1_axi_wvalid);
  assign w_g_bready  = (r_wr_grant[0] & s0_axi_bready)  | (r_wr_grant[1] & s1_axi_bready);
  assign w_g_arvalid = (r_rd_grant[0] & s0_axi_arvalid) | (r_rd_grant[1] & s1_axi_arvalid);
  assign w_g_rready  = (r_rd_grant[0] & s0_axi_rready)  | (r_rd_grant[1] & s1_axi_rready);

  // Downstream side: payload follows the grant, valids are masked once their handshake is done.
  assign m_axi_awaddr  = r_wr_grant[1] ? s1_axi_awaddr : s0_axi_awaddr;
  assign m_axi_wdata   = r_wr_grant[1] ? s1_axi_wdata  : s0_axi_wdata;
  assign m_axi_wstrb   = r_wr_grant[1] ? s1_axi_wstrb  : s0_axi_wstrb;
  assign m_axi_araddr  = r_rd_grant[1] ? s1_axi_araddr : s0_axi_araddr;
  assign m_axi_awvalid = w_wr_addr & w_g_awvalid & ~r_aw_done;
  assign m_axi_wvalid  = w_wr_addr & w_g_wvalid  & ~r_w_done;
  assign m_axi_bready  = w_wr_resp & w_g_bready;
  assign m_axi_arvalid = w_rd_addr & w_g_arvalid;
  assign m_axi_rready  = w_rd_data & w_g_rready;

  assign w_aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_w_hs  = m_axi_wvalid  & m_axi_wready;
  assign w_b_hs  = m_axi_bvalid  & m_axi_bready;
  assign w_ar_hs = m_axi_arvalid & m_axi_arready;
  assign w_r_hs  = m_axi_rvalid  & m_axi_rready;

  // Upstream side: only the granted master sees ready/valid; responses read as zero otherwise.
  assign s0_axi_awready = r_wr_grant[0] & w_wr_addr & ~r_aw_done & m_axi_awready;
  assign s1_axi_awready = r_wr_grant[1] & w_wr_addr & ~r_aw_done & m_axi_awready;
  assign s0_axi_wready  = r_wr_grant[0] & w_wr_addr & ~r_w_done & m_axi_wready;
  assign s1_axi_wready  = r_wr_grant[1] & w_wr_addr & ~r_w_done & m_axi_wready;
  assign s0_axi_bvalid  = r_wr_grant[0] & w_wr_resp & m_axi_bvalid;
  assign s1_axi_bvalid  = r_wr_grant[1] & w_wr_resp & m_axi_bvalid;
  assign s0_axi_bresp   = (r_wr_grant[0] & w_wr_resp) ? m_axi_bresp : RESP_OKAY;
  assign s1_axi_bresp   = (r_wr_grant[1] & w_wr_resp) ? m_axi_bresp : RESP_OKAY;
  assign s0_axi_arready = r_rd_grant[0] & w_rd_addr & m_axi_arready;
  assign s1_axi_arready = r_rd_grant[1] & w_rd_addr & m_axi_arready;
  assign s0_axi_rvalid  = r_rd_grant[0] & w_rd_data & m_axi_rvalid;
  assign s1_axi_rvalid  = r_rd_grant[1] & w_rd_data & m_axi_rvalid;
  assign s0_axi_rresp   = (r_rd_grant[0] & w_rd_data) ? m_axi_rresp : RESP_OKAY;
  assign s1_axi_rresp   = (r_rd_grant[1] & w_rd_data) ? m_axi_rresp : RESP_OKAY;
  assign s0_axi_rdata   = (r_rd_grant[0] & w_rd_data) ? m_axi_rdata : '0;
  assign s1_axi_rdata   = (r_rd_grant[1] & w_rd_data) ? m_axi_rdata : '0;

  assign wr_grant = r_wr_grant;
  assign rd_grant = r_rd_grant;

  // Write FSM next state; done flags persist through W_RESP and clear on the B handshake.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_grant_nxt = r_wr_grant;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_wr_prio_nxt  = r_wr_prio;
    case (r_wr_state)
      W_IDLE: begin
        if (|w_wr_pick) begin
          w_wr_grant_nxt = w_wr_pick;
          w_wr_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        w_aw_done_nxt = r_aw_done | w_aw_hs;
        w_w_done_nxt  = r_w_done  | w_w_hs;
        if (w_aw_done_nxt && w_w_done_nxt) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_wr_state_nxt = W_IDLE;
          w_wr_grant_nxt = 2'b00;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_wr_prio_nxt  = r_wr_grant[0];
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Read FSM next state; same shape as the write side with a single address channel.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_grant_nxt = r_rd_grant;
    w_rd_prio_nxt  = r_rd_prio;
    case (r_rd_state)
      R_IDLE: begin
        if (|w_rd_pick) begin
          w_rd_grant_nxt = w_rd_pick;
          w_rd_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        if (w_ar_hs) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rd_state_nxt = R_IDLE;
          w_rd_grant_nxt = 2'b00;
          w_rd_prio_nxt  = r_rd_grant[0];
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // State, grant, done and priority registers for both directions.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state <= W_IDLE;
      r_wr_grant <= 2'b00;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_wr_prio  <= 1'b0;
      r_rd_state <= R_IDLE;
      r_rd_grant <= 2'b00;
      r_rd_prio  <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_grant <= w_wr_grant_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_wr_prio  <= w_wr_prio_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_rd_grant <= w_rd_grant_nxt;
      r_rd_prio  <= w_rd_prio_nxt;
    end
  end

endmodule

// File: doc/axi_lite_arb2.md
# axi_lite_arb2

Two-master AXI-Lite arbiter in front of the single-port AXI slave/RAM controller. It lets two independent AXI-Lite masters share one downstream slave. Write and read paths are arbitrated independently, each with round-robin priority and one outstanding transaction per direction. All upstream signals are combinationally routed to or from the granted master; grant state is registered.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports (`s{0,1}_` denotes one port per upstream master):
- aclk  in  1  clock
- aresetn  in  1  asynchronous, active-low reset
- s{0,1}_axi_awaddr / awvalid  in  ADDR_WIDTH / 1  upstream write address
- s{0,1}_axi_awready  out  1  upstream write address ready
- s{0,1}_axi_wdata / wstrb / wvalid  in  DATA_WIDTH / DATA_WIDTH/8 / 1  upstream write data
- s{0,1}_axi_wready  out  1  upstream write data ready
- s{0,1}_axi_bresp / bvalid  out  2 / 1  upstream write response
- s{0,1}_axi_bready  in  1  upstream write response ready
- s{0,1}_axi_araddr / arvalid  in  ADDR_WIDTH / 1  upstream read address
- s{0,1}_axi_arready  out  1  upstream read address ready
- s{0,1}_axi_rdata / rresp / rvalid  out  DATA_WIDTH / 2 / 1  upstream read data
- s{0,1}_axi_rready  in  1  upstream read data ready
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  mirror  same widths  downstream master port, same signal set with directions reversed
- wr_grant  out  2  one-hot write grant (00 when idle)
- rd_grant  out  2  one-hot read grant (00 when idle)

## Operation
- **Write FSM states:** W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: if any s*_awvalid is high, latch the winner into wr_grant and go to W_ADDR. The winner is chosen by rr_arb2 from wr_prio.
  - W_ADDR: forward the granted AW and W channels. Registered aw_done is set on the m_axi AW handshake; w_done is set on the m_axi W handshake. Once a channel's handshake completes, its downstream valid is masked: m_axi_awvalid = granted awvalid & ~aw_done, and likewise for wvalid. Go to W_RESP when both handshakes are complete. This includes both completing in the same cycle, or one completing while the other is already done.
  - W_RESP: route m_axi_bresp/bvalid to the granted master; m_axi_bready = granted bready. On the B handshake: go to W_IDLE, clear wr_grant, aw_done and w_done, and set wr_prio to the non-granted master.
- **Read FSM states:** R_IDLE, R_ADDR, R_DATA. Same pattern: AR handshake moves R_ADDR to R_DATA; R handshake moves R_DATA to R_IDLE and updates rd_prio.
- **Arbitration:**
  - If only one master requests, it wins regardless of priority.
  - If both request, the master selected by the prio pointer wins.
  - Requests arriving in ADDR/DATA/RESP states are ignored; the losing master stalls with ready=0.
- **Non-granted master:** awready, wready, arready, bvalid and rvalid are all 0.
- **Data passthrough:** bresp and rdata/rresp are passed through unmodified. No decode and no error generation.
- **Independence:** the read and write FSMs are independent and may be active in the same cycle for different masters.

## Timing
- **Reset values:**
  - All ready and valid outputs are 0.
  - wr_grant = rd_grant = 00.
  - bresp/rresp/rdata pass-through are 0 while idle.
  - wr_prio = rd_prio = master 0.
  - Both FSMs are in IDLE; done flags are cleared.
- **Grant latency:** a request seen in cycle T gives a grant in T+1. The downstream valid is asserted in T+1, combinationally from the granted master.
- **Throughput:** per direction, back-to-back transactions have at least one IDLE cycle between them.
- **Reset mid-transaction:** aresetn low aborts immediately and asynchronously to the reset state. No completion is issued to the upstream master. The downstream slave shares the same reset.
- **Upstream protocol assumption:** a master holds valid until its handshake, per AXI. The arbiter never deasserts a forwarded valid before its handshake.

## Structure
- **Package axi_arb_pkg:**
  - FSM state localparams W_IDLE/W_ADDR/W_RESP and R_IDLE/R_ADDR/R_DATA.
  - RESP_OKAY = 2'b00.
- **Sub-module rr_arb2:** combinational two-way round-robin pick.
  - Inputs: req[1:0], prio.
  - Output: one-hot gnt.
  - Instantiated twice (write and read).
- Muxing of payload and valid/ready signals is done in the top level.

## Test plan
- **Single write:** s0 writes addr 0x10, data 0xDEADBEEF. Expect wr_grant=01 one cycle later, downstream AW/W handshake, then s0_bvalid=1 with bresp=00, then wr_grant=00.
- **Contention after reset:** s0 and s1 request writes in the same cycle. s0 is served first; s1 stalls with awready=0, then is granted after s0's B handshake.
- **Round-robin:** with both requesting continuously, the grant sequence is 01, 10, 01, 10 for both writes and reads.
- **Concurrent read and write:** s1 reads addr 0x10 while s0 writes addr 0x20. Both complete; s1_rdata = 0xDEADBEEF; rd_grant=10 and wr_grant=01 in overlapping cycles.
- **Stalled response and reset:**
  - Backpressure: s0_bready held low for 5 cycles. bvalid stays high, the FSM stays in W_RESP, and s1's request waits.
  - Reset: aresetn pulsed low in W_ADDR. All outputs return to reset values in the same cycle; the next s1 request is granted normally.
